// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MDU_HILO_WRITE_EN to add the MTHI/MTLO write ports (hiWrite, loWrite, wdata).
module alu_muldiv #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   mdControl,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
`ifdef MDU_HILO_WRITE_EN
    input  logic         hiWrite,
    input  logic         loWrite,
    input  logic [N-1:0] wdata,
`endif
    output logic         busy,
    output logic         done,
    output logic         divByZero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);
    localparam int unsigned CntW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [N-1:0]    opnd_q, opnd_d;  // multiplicand magnitude (mul) or divisor magnitude (div)
    logic [N-1:0]    a_q, a_d;
    logic            is_div_q, is_div_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic [N-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;

    logic            is_signed, neg_a, neg_b;
    logic [N-1:0]    mag_a, mag_b;
    logic [N:0]      mul_sum, rem_shift, rem_diff;
    logic [2*N-1:0]  prod;
    logic [N-1:0]    quot, rem;

    always_comb begin
        is_signed = ~mdControl[0];
        neg_a     = is_signed & a[N-1];
        neg_b     = is_signed & b[N-1];
        mag_a     = neg_a ? -a : a;
        mag_b     = neg_b ? -b : b;

        mul_sum   = {1'b0, acc_q[2*N-1:N]} + {1'b0, opnd_q};
        rem_shift = acc_q[2*N-1:N-1];
        rem_diff  = rem_shift - {1'b0, opnd_q};

        prod      = neg_res_q ? -acc_q : acc_q;
        quot      = neg_res_q ? -acc_q[N-1:0] : acc_q[N-1:0];
        rem       = neg_rem_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];

        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        a_d       = a_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StCalc;
                    cnt_d     = '0;
                    is_div_d  = mdControl[1];
                    a_d       = a;
                    neg_res_d = neg_a ^ neg_b;
                    neg_rem_d = neg_a;
                    opnd_d    = mdControl[1] ? mag_b : mag_a;
                    acc_d     = {{N{1'b0}}, (mdControl[1] ? mag_a : mag_b)};
                end
`ifdef MDU_HILO_WRITE_EN
                if (hiWrite) hi_d = wdata;
                if (loWrite) lo_d = wdata;
`endif
            end
            StCalc: begin
                if (is_div_q) begin
                    // Restoring step: keep the trial subtraction only when it does not borrow
                    if (!rem_diff[N]) acc_d = {rem_diff[N-1:0], acc_q[N-2:0], 1'b1};
                    else              acc_d = {rem_shift[N-1:0], acc_q[N-2:0], 1'b0};
                end else begin
                    if (acc_q[0]) acc_d = {mul_sum, acc_q[N-1:1]};
                    else          acc_d = {1'b0, acc_q[2*N-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(N - 1)) state_d = StFinish;
            end
            StFinish: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (is_div_q) begin
                    if (opnd_q == '0) begin
                        lo_d  = '1;
                        hi_d  = a_q;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d  = quot;
                        hi_d  = rem;
                        dbz_d = 1'b0;
                    end
                end else begin
                    {hi_d, lo_d} = prod;
                    dbz_d        = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            a_q       <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            a_q       <= a_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign divByZero = dbz_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (N=32): vector table, scoreboard queue, handshake corners.
module tb_alu_muldiv;
    localparam int N = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    mdc;
    logic [N-1:0]  a, b;
    logic          busy, done, dbz;
    logic [N-1:0]  hi, lo;
`ifdef MDU_HILO_WRITE_EN
    logic          hi_wr, lo_wr;
    logic [N-1:0]  wdata;
`endif

    alu_muldiv #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mdControl (mdc),
        .a         (a),
        .b         (b),
`ifdef MDU_HILO_WRITE_EN
        .hiWrite   (hi_wr),
        .loWrite   (lo_wr),
        .wdata     (wdata),
`endif
        .busy      (busy),
        .done      (done),
        .divByZero (dbz),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   ctrl;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        logic         dbz;
    } vec_t;

    typedef struct {
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        logic         dbz;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present an op; when sync is set, align to a falling edge first. Returns #1 after accept edge.
    task automatic launch(input bit sync, input logic [1:0] ctrl, input logic [N-1:0] av,
                          input logic [N-1:0] bv);
        if (sync) @(negedge clk);
        start = 1'b1;
        mdc   = ctrl;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        mdc   = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input int c0);
        int   lat;
        exp_t e;
        lat = -1;
        for (int c = c0 + 1; c <= N + 4; c++) begin
            @(posedge clk);
            #1;
            check("busy_vs_done", 64'(busy), 64'(!done));
            if (done) begin
                lat = c;
                break;
            end
        end
        check("latency", 64'(lat), 64'(N + 1));
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check("hi", 64'(hi), 64'(e.hi));
            check("lo", 64'(lo), 64'(e.lo));
            check("divByZero", 64'(dbz), 64'(e.dbz));
        end
    endtask

    initial begin
        vecs[0]  = '{2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[1]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{2'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
        vecs[4]  = '{2'd3, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{2'd0, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0};
        vecs[6]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[7]  = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{2'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[10] = '{2'd1, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b0};
        vecs[11] = '{2'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
        vecs[12] = '{2'd0, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        mdc   = '0;
        a     = '0;
        b     = '0;
`ifdef MDU_HILO_WRITE_EN
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        wdata = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(dbz), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            launch(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b);
            sb.push_back('{vecs[i].hi, vecs[i].lo, vecs[i].dbz});
            wait_done(0);
        end

        // A second start mid-operation must be ignored entirely.
        launch(1'b1, 2'd1, 32'd2, 32'd3);
        sb.push_back('{32'd0, 32'd6, 1'b0});
        repeat (5) @(negedge clk);
        start = 1'b1;
        mdc   = 2'd1;
        a     = 32'd9;
        b     = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(5);

        // Back-to-back: start raised in the done cycle is accepted; HI/LO hold meanwhile.
        launch(1'b1, 2'd1, 32'd5, 32'd7);
        sb.push_back('{32'd0, 32'd35, 1'b0});
        wait_done(0);
        launch(1'b0, 2'd0, 32'hFFFFFFFF, 32'd2);
        sb.push_back('{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0});
        check("b2b_hold_lo", 64'(lo), 64'd35);
        check("b2b_hold_hi", 64'(hi), 64'd0);
        wait_done(0);

`ifdef MDU_HILO_WRITE_EN
        @(negedge clk);
        lo_wr = 1'b1;
        hi_wr = 1'b1;
        wdata = 32'h12345678;
        @(posedge clk);
        #1;
        lo_wr = 1'b0;
        hi_wr = 1'b0;
        check("mtlo_idle", 64'(lo), 64'h12345678);
        check("mthi_idle", 64'(hi), 64'h12345678);
        launch(1'b1, 2'd1, 32'd1, 32'd1);
        sb.push_back('{32'd0, 32'd1, 1'b0});
        lo_wr = 1'b1;
        wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        lo_wr = 1'b0;
        check("mtlo_busy_ignored", 64'(lo), 64'h12345678);
        wait_done(1);
        lo_wr = 1'b1;
        wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        lo_wr = 1'b0;
        check("mtlo_done_wins", 64'(lo), 64'hCAFEF00D);
`endif

        // Reset ten cycles into an op clears everything at once.
        launch(1'b1, 2'd1, 32'd11, 32'd13);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (N + 4) @(posedge clk);
        #1;
        check("midrst_no_result", 64'(lo), 64'd0);
        check("midrst_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
